// File: rtl/bluetooth_uart_rx.sv
// 8N1 UART receiver feeding bluetooth_decoder's sig_bt bus, with valid/frame-error strobes and busy flag.
// Define BT_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module bluetooth_uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK_100MHz,
    input  logic       rst_n,
    input  logic       bt_rx,
    output logic [7:0] sig_bt,
    output logic       bt_valid,
    output logic       bt_frame_err,
    output logic       bt_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef BT_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       sig_q, sig_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
`ifdef BT_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    always_ff @(posedge CLK_100MHz) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            sig_q     <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef BT_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= bt_rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            sig_q     <= sig_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef BT_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sig_d     = sig_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef BT_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck rejects short glitches on the line.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef BT_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef BT_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rx_s_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
`ifdef BT_RX_PARITY_EN
                        if (par_err_q) begin
                            err_d = 1'b1;
                        end else begin
                            sig_d   = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        sig_d   = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low break must not look like a train of start bits.
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign sig_bt       = sig_q;
    assign bt_valid     = valid_q;
    assign bt_frame_err = err_q;
    assign bt_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_bluetooth_uart_rx.sv
// Directed bench for bluetooth_uart_rx at 10 clocks per bit: frame table plus glitch, break and reset corner cases.
module tb_bluetooth_uart_rx;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bt_rx;
    logic [7:0] sig_bt;
    logic       bt_valid, bt_frame_err, bt_busy;

    always #5 clk = ~clk;

    bluetooth_uart_rx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .CLK_100MHz  (clk),
        .rst_n       (rst_n),
        .bt_rx       (bt_rx),
        .sig_bt      (sig_bt),
        .bt_valid    (bt_valid),
        .bt_frame_err(bt_frame_err),
        .bt_busy     (bt_busy)
    );

    int n_pass = 0, n_total = 0;
    int n_valid = 0, n_err = 0;
    bit both_seen = 1'b0;

    always @(negedge clk) begin
        if (bt_valid) n_valid++;
        if (bt_frame_err) n_err++;
        if (bt_valid && bt_frame_err) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        bt_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bt_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef BT_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) bt_rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        int         idle_after;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_sig;
    } vec_t;

    vec_t tbl[6];
    int   v0, e0;

    initial begin
        tbl[0] = '{8'h35, 3, 1, 0, 8'h35};
        tbl[1] = '{8'hA7, 0, 1, 0, 8'hA7};  // back-to-back with next
        tbl[2] = '{8'h3C, 2, 1, 0, 8'h3C};
        tbl[3] = '{8'hFF, 0, 1, 0, 8'hFF};
        tbl[4] = '{8'h00, 0, 1, 0, 8'h00};
        tbl[5] = '{8'h80, 4, 1, 0, 8'h80};

        bt_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig", sig_bt, 8'h00);
        check("rst_valid", bt_valid, 0);
        check("rst_err", bt_frame_err, 0);
        check("rst_busy", bt_busy, 0);
        rst_n = 1'b1;
        idle(5);
        check("post_rst_sig", sig_bt, 8'h00);
        check("post_rst_busy", bt_busy, 0);
        check("post_rst_strobes", n_valid + n_err, 0);

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(tbl[k].data, ^tbl[k].data, 1'b1);
            check($sformatf("vec%0d_valid", k), n_valid - v0, tbl[k].exp_v);
            check($sformatf("vec%0d_err", k), n_err - e0, tbl[k].exp_e);
            check($sformatf("vec%0d_sig", k), sig_bt, tbl[k].exp_sig);
            check($sformatf("vec%0d_busy", k), bt_busy, 0);
            if (k == 0) check("decoder_digit", sig_bt - 8'h30, 5);
            if (tbl[k].idle_after > 0) idle(tbl[k].idle_after);
        end

        // Short low glitch: START entered, then rejected at the mid-bit recheck.
        v0 = n_valid;
        e0 = n_err;
        bt_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy_hi", bt_busy, 1);
        idle(15);
        check("glitch_busy_lo", bt_busy, 0);
        check("glitch_strobes", (n_valid - v0) + (n_err - e0), 0);
        check("glitch_sig", sig_bt, 8'h80);

        // Bad stop bit followed by a long break.
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h5A, ^8'h5A, 1'b0);
        check("brk_err", n_err - e0, 1);
        check("brk_valid", n_valid - v0, 0);
        check("brk_sig", sig_bt, 8'h80);
        bt_rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("brk_hold_busy", bt_busy, 1);
        check("brk_hold_sig", sig_bt, 8'h80);
        check("brk_hold_err", n_err - e0, 1);
        idle(12);
        check("brk_recover_busy", bt_busy, 0);
        v0 = n_valid;
        send_frame(8'h12, ^8'h12, 1'b1);
        check("after_brk_valid", n_valid - v0, 1);
        check("after_brk_sig", sig_bt, 8'h12);
        check("brk_total_err", n_err - e0, 1);
        idle(3);

`ifdef BT_RX_PARITY_EN
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_valid", n_valid - v0, 1);
        check("par_ok_sig", sig_bt, 8'h07);
        idle(3);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_bad_err", n_err - e0, 1);
        check("par_bad_valid", n_valid - v0, 0);
        check("par_bad_sig", sig_bt, 8'h07);
        check("par_bad_busy", bt_busy, 0);
        idle(3);
`endif

        // Reset in the middle of a frame aborts it silently.
        v0 = n_valid;
        e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        bt_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(30);
        check("abort_strobes", (n_valid - v0) + (n_err - e0), 0);
        check("abort_sig", sig_bt, 8'h00);
        check("abort_busy", bt_busy, 0);

        check("never_both", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bluetooth_uart_rx.md
Name: bluetooth_uart_rx

Overview:
- UART receiver for the Bluetooth serial module's TX line (8N1, LSB first).
- Assembles bytes and presents them as the 8-bit sig_bt bus consumed directly by bluetooth_decoder.
- Sits between the board pin and bluetooth_decoder.
- Adds a per-byte valid strobe, a frame-error strobe and a busy flag for downstream control logic.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer, truncated; 10416 at defaults): clocks per bit. Derived localparam, not overridden directly.
- HALF_BIT, CLKS_PER_BIT/2 (5208 at defaults): offset from the start edge to the first mid-bit sample. Derived localparam.

Ports:
- CLK_100MHz, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- bt_rx, input, 1: asynchronous serial line from the Bluetooth module; idle high.
- sig_bt, output, 8: last correctly received byte; holds until the next good byte.
- bt_valid, output, 1: one-cycle pulse when sig_bt is updated.
- bt_frame_err, output, 1: one-cycle pulse on a bad stop bit (or bad parity, see Optional Feature).
- bt_busy, output, 1: high while in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clock edge):
  - sig_bt=8'h00, bt_valid=0, bt_frame_err=0, bt_busy=0.
  - Both synchronizer flops=1, state=IDLE, bit counter and baud counter=0.
  - Reset mid-frame aborts the frame; no strobe is issued.
- Synchronizer: two flops on bt_rx. All decisions use the second flop (rx_s). Pin-to-rx_s latency is 2 cycles.
- Baud counter: counts 0..limit-1 and is cleared on every state transition.
- IDLE:
  - rx_s==0 -> START, baud counter cleared.
- START:
  - At count HALF_BIT-1, sample rx_s.
  - rx_s==0 -> DATA, bit index 0.
  - rx_s==1 -> IDLE (glitch rejected; no strobe).
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index]; LSB received first.
  - After bit 7 is sampled -> STOP (or PARITY when the feature is enabled).
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1: sig_bt<=shift register; bt_valid=1 for exactly the next cycle; -> IDLE.
  - rx_s==0: bt_frame_err=1 for one cycle; sig_bt unchanged; -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then -> IDLE.
  - Prevents a held-low break condition from being read as a stream of start bits.
- Timing:
  - Return to IDLE occurs at mid-stop-bit, so back-to-back frames with a single stop bit are accepted.
  - Latency from the stop-bit mid-sample to the bt_valid rising edge: 1 cycle.
  - bt_valid and bt_frame_err are never high in the same cycle.
- Reserved encodings: unused state encodings recover to IDLE.

Optional Feature:
- Macro: BT_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP, sampled after CLKS_PER_BIT cycles.
  - Even parity is computed over the 8 data bits plus the parity bit.
  - On a parity mismatch, a good stop bit still yields bt_frame_err=1 (sig_bt unchanged) and a direct return to IDLE.
  - A bad stop bit behaves as in the base design.
- Undefined:
  - The PARITY state and parity logic are absent; the frame is 8N1 exactly as above.

Test Plan (bench uses CLK_FREQ=1000000, BAUD=100000 -> CLKS_PER_BIT=10, HALF_BIT=5):
- rst_n low for 3 cycles, bt_rx=1 -> sig_bt=8'h00, bt_valid=0, bt_frame_err=0, bt_busy=0; all hold after release.
- Send 8'h35 ('5') 8N1 -> exactly one bt_valid pulse; sig_bt=8'h35; bluetooth_decoder sig_num=4'h5; bt_busy low after the pulse.
- Send 8'hA7 then 8'h3C back-to-back with one stop bit each -> two bt_valid pulses; sig_bt=8'hA7, then 8'h3C.
- Drive bt_rx low for 3 cycles only -> returns to IDLE after the START sample; no strobes; sig_bt unchanged.
- Send 8'h5A with stop bit=0, hold line low for 40 cycles, then send 8'h12 -> one bt_frame_err pulse; sig_bt stays at its prior value through the break; then sig_bt=8'h12 with one bt_valid.
- BT_RX_PARITY_EN defined: send 8'h07 with parity bit 1 -> bt_valid, sig_bt=8'h07. Send 8'h07 with parity bit 0 -> bt_frame_err, sig_bt unchanged.
